// File: rtl/step_phase_decoder_pkg.sv
// Shared half-step phase definitions: coil-drive table, OFF word, decoder FSM states.
// The same table drives the phase generator, so both ends agree on index order.
package step_pkg;

   localparam logic [3:0] PH_OFF = 4'b0000;

   // Packed so element i is PHASE_TABLE[i]; idx0 sits in the low nibble.
   localparam logic [7:0][3:0] PHASE_TABLE = {
      4'b1001, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0100, 4'b1100, 4'b1000
   };

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] idx;
      logic       legal;
      logic       off;
   } dec_t;

   function automatic dec_t phase_decode(input logic [3:0] word);
      dec_t d;
      d.idx   = 3'd0;
      d.legal = 1'b0;
      d.off   = (word == PH_OFF);
      for (int i = 0; i < 8; i++) begin
         if (word == PHASE_TABLE[i[2:0]]) begin
            d.idx   = i[2:0];
            d.legal = 1'b1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/step_phase_decoder_sync.sv
// Multi-stage flop chain bringing the asynchronous coil-drive word into the clk domain.
module step_sync #(
   parameter int STAGES = 2,
   parameter int W      = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= din;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign dout = chain[STAGES-1];

endmodule

// File: rtl/step_phase_decoder.sv
// Half-step phase bus decoder: phase index, step pulses, signed position, error/stall flags.
// Every action is registered, so it appears one cycle after the synchronizer output changes.
module step_phase_decoder
   import step_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int POS_W        = 16,
   parameter int STALL_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              phase_in,
   input  logic                    pos_clr,
   input  logic                    err_clr,
   output logic [2:0]              phase_idx,
   output logic                    step_fwd,
   output logic                    step_rev,
   output logic                    dir,
   output logic signed [POS_W-1:0] position,
   output logic                    locked,
   output logic                    err_skip,
   output logic                    err_illegal,
   output logic                    stalled
);

   localparam int CW = $clog2(STALL_CYCLES + 1);
   localparam logic [CW-1:0] STALL_MAX = CW'(STALL_CYCLES);

   logic [3:0]    phase_s;
   dec_t          dec;
   logic [2:0]    delta;
   state_t        state, state_nxt;
   logic          fwd, rev, skip, illegal, load_idx;
   logic [CW-1:0] stall_cnt;

   step_sync #(.STAGES(SYNC_STAGES), .W(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (phase_in),
      .dout  (phase_s)
   );

   assign dec   = phase_decode(phase_s);
   assign delta = dec.idx - phase_idx;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_UNLOCKED;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_UNLOCKED: if (dec.legal) state_nxt = ST_LOCKED;
         ST_LOCKED: begin
            if (dec.off)         state_nxt = ST_UNLOCKED;
            else if (!dec.legal) state_nxt = ST_FAULT;
         end
         ST_FAULT: begin
            if (dec.legal)     state_nxt = ST_LOCKED;
            else if (dec.off)  state_nxt = ST_UNLOCKED;
         end
         default: state_nxt = ST_UNLOCKED;
      endcase
   end

   // Steps only count against an existing reference; entering LOCKED just loads the index.
   always_comb begin
      fwd      = 1'b0;
      rev      = 1'b0;
      skip     = 1'b0;
      illegal  = !dec.legal && !dec.off;
      load_idx = dec.legal;
      if (state == ST_LOCKED && dec.legal) begin
         if (delta == 3'd1)      fwd  = 1'b1;
         else if (delta == 3'd7) rev  = 1'b1;
         else if (delta != 3'd0) skip = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_idx   <= '0;
         step_fwd    <= 1'b0;
         step_rev    <= 1'b0;
         dir         <= 1'b0;
         position    <= '0;
         err_skip    <= 1'b0;
         err_illegal <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         step_fwd <= fwd;
         step_rev <= rev;
         if (load_idx) phase_idx <= dec.idx;
         if (fwd)      dir <= 1'b1;
         else if (rev) dir <= 1'b0;
         if (pos_clr)  position <= '0;
         else if (fwd) position <= position + POS_W'(1);
         else if (rev) position <= position - POS_W'(1);
         err_skip    <= skip    | (err_skip    & ~err_clr);
         err_illegal <= illegal | (err_illegal & ~err_clr);
         if (fwd || rev || state != ST_LOCKED) stall_cnt <= '0;
         else if (stall_cnt != STALL_MAX)       stall_cnt <= stall_cnt + CW'(1);
      end
   end

   assign locked  = (state == ST_LOCKED);
   assign stalled = (stall_cnt == STALL_MAX) && locked;

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench: dut_a uses default parameters, dut_b uses POS_W=4 / STALL_CYCLES=10.
module tb_step_phase_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  phase_in = 4'b0000;
   logic        pos_clr = 1'b0;
   logic        err_clr = 1'b0;

   logic [2:0]  phase_idx_a, phase_idx_b;
   logic        step_fwd_a, step_rev_a, dir_a, locked_a, err_skip_a, err_illegal_a, stalled_a;
   logic        step_fwd_b, step_rev_b, dir_b, locked_b, err_skip_b, err_illegal_b, stalled_b;
   logic [15:0] position_a;
   logic [3:0]  position_b;

   int errors = 0;
   int checks = 0;
   logic [3:0] ptab [8];

   always #5 clk = ~clk;

   step_phase_decoder #(.SYNC_STAGES(2), .POS_W(16), .STALL_CYCLES(1000)) dut_a (
      .clk(clk), .reset(reset), .phase_in(phase_in), .pos_clr(pos_clr), .err_clr(err_clr),
      .phase_idx(phase_idx_a), .step_fwd(step_fwd_a), .step_rev(step_rev_a), .dir(dir_a),
      .position(position_a), .locked(locked_a), .err_skip(err_skip_a),
      .err_illegal(err_illegal_a), .stalled(stalled_a)
   );

   step_phase_decoder #(.SYNC_STAGES(2), .POS_W(4), .STALL_CYCLES(10)) dut_b (
      .clk(clk), .reset(reset), .phase_in(phase_in), .pos_clr(pos_clr), .err_clr(err_clr),
      .phase_idx(phase_idx_b), .step_fwd(step_fwd_b), .step_rev(step_rev_b), .dir(dir_b),
      .position(position_b), .locked(locked_b), .err_skip(err_skip_b),
      .err_illegal(err_illegal_b), .stalled(stalled_b)
   );

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      phase_in = 4'b0000;
      pos_clr = 1'b0;
      err_clr = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      phase_in = 4'b1000;
      cyc(4);
      checks++;
      if ({phase_idx_a, step_fwd_a, step_rev_a, dir_a, position_a, locked_a, err_skip_a,
           err_illegal_a, stalled_a} !== 26'd0) begin
         errors++;
         $display("FAIL reset_a got=%h exp=0", {phase_idx_a, step_fwd_a, step_rev_a, dir_a,
                  position_a, locked_a, err_skip_a, err_illegal_a, stalled_a});
      end
      checks++;
      if ({phase_idx_b, step_fwd_b, step_rev_b, dir_b, position_b, locked_b, err_skip_b,
           err_illegal_b, stalled_b} !== 14'd0) begin
         errors++;
         $display("FAIL reset_b got=%h exp=0", {phase_idx_b, step_fwd_b, step_rev_b, dir_b,
                  position_b, locked_b, err_skip_b, err_illegal_b, stalled_b});
      end
      do_reset();
   endtask

   task automatic test_forward();
      phase_in = 4'b1000;
      cyc(2);
      checks++;
      if (locked_a !== 1'b0) begin errors++; $display("FAIL lock_early got=%b exp=0", locked_a); end
      cyc(1);
      checks++;
      if ({locked_a, phase_idx_a, step_fwd_a} !== {1'b1, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL lock got=%b/%0d/%b exp=1/0/0", locked_a, phase_idx_a, step_fwd_a);
      end
      for (int i = 1; i <= 3; i++) begin
         phase_in = ptab[i];
         cyc(2);
         checks++;
         if (step_fwd_a !== 1'b0) begin errors++; $display("FAIL fwd_early%0d got=1 exp=0", i); end
         cyc(1);
         checks++;
         if (step_fwd_a !== 1'b1) begin errors++; $display("FAIL fwd_pulse%0d got=0 exp=1", i); end
      end
      checks++;
      if ({position_a, dir_a} !== {16'd3, 1'b1}) begin
         errors++;
         $display("FAIL fwd_pos got=%0d/%b exp=3/1", $signed(position_a), dir_a);
      end
   endtask

   task automatic test_reverse();
      logic [3:0] seq [4];
      seq = '{4'b0100, 4'b1100, 4'b1000, 4'b1001};
      for (int i = 0; i < 4; i++) begin
         phase_in = seq[i];
         cyc(3);
         checks++;
         if ({step_rev_a, step_fwd_a} !== 2'b10) begin
            errors++;
            $display("FAIL rev_pulse%0d got=%b%b exp=10", i, step_rev_a, step_fwd_a);
         end
      end
      checks++;
      if ({position_a, dir_a, phase_idx_a} !== {16'hFFFF, 1'b0, 3'd7}) begin
         errors++;
         $display("FAIL rev_pos got=%0d/%b/%0d exp=-1/0/7", $signed(position_a), dir_a, phase_idx_a);
      end
   endtask

   task automatic test_skip();
      do_reset();
      phase_in = 4'b1000;
      cyc(3);
      phase_in = 4'b0110;
      cyc(3);
      checks++;
      if ({err_skip_a, step_fwd_a, step_rev_a, position_a, phase_idx_a} !== {3'b100, 16'd0, 3'd3}) begin
         errors++;
         $display("FAIL skip got=%b%b%b/%0d/%0d exp=100/0/3", err_skip_a, step_fwd_a, step_rev_a,
                  $signed(position_a), phase_idx_a);
      end
      phase_in = 4'b0010;
      cyc(3);
      checks++;
      if ({step_fwd_a, position_a} !== {1'b1, 16'd1}) begin
         errors++;
         $display("FAIL skip_then_fwd got=%b/%0d exp=1/1", step_fwd_a, $signed(position_a));
      end
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      checks++;
      if (err_skip_a !== 1'b0) begin errors++; $display("FAIL err_clr got=1 exp=0"); end
      phase_in = 4'b1000;
      cyc(2);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      checks++;
      if (err_skip_a !== 1'b1) begin errors++; $display("FAIL set_wins got=0 exp=1"); end
   endtask

   task automatic test_illegal();
      do_reset();
      phase_in = 4'b1000;
      cyc(3);
      phase_in = 4'b1100;
      cyc(3);
      phase_in = 4'b1111;
      cyc(3);
      checks++;
      if ({err_illegal_a, locked_a, step_fwd_a, step_rev_a} !== 4'b1000) begin
         errors++;
         $display("FAIL illegal got=%b%b%b%b exp=1000", err_illegal_a, locked_a, step_fwd_a, step_rev_a);
      end
      phase_in = 4'b0100;
      cyc(3);
      checks++;
      if ({locked_a, step_fwd_a, phase_idx_a, position_a} !== {2'b10, 3'd2, 16'd1}) begin
         errors++;
         $display("FAIL relock got=%b%b/%0d/%0d exp=10/2/1", locked_a, step_fwd_a, phase_idx_a,
                  $signed(position_a));
      end
      phase_in = 4'b0000;
      cyc(3);
      checks++;
      if ({locked_a, position_a, phase_idx_a} !== {1'b0, 16'd1, 3'd2}) begin
         errors++;
         $display("FAIL off got=%b/%0d/%0d exp=0/1/2", locked_a, $signed(position_a), phase_idx_a);
      end
   endtask

   task automatic test_wrap();
      int idx;
      logic [3:0] exp_pos;
      do_reset();
      idx = 0;
      phase_in = ptab[0];
      cyc(3);
      exp_pos = 4'd0;
      for (int i = 1; i <= 15; i++) begin
         idx = (idx + 1) % 8;
         phase_in = ptab[idx];
         cyc(3);
         exp_pos = exp_pos + 4'd1;
         if (i == 7 || i == 8 || i == 15) begin
            checks++;
            if ({step_fwd_b, position_b} !== {1'b1, exp_pos}) begin
               errors++;
               $display("FAIL wrap%0d got=%b/%h exp=1/%h", i, step_fwd_b, position_b, exp_pos);
            end
         end
      end
      idx = (idx + 1) % 8;
      phase_in = ptab[idx];
      cyc(2);
      pos_clr = 1'b1;
      cyc(1);
      pos_clr = 1'b0;
      checks++;
      if ({step_fwd_b, position_b} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL clr_wins got=%b/%h exp=1/0", step_fwd_b, position_b);
      end
   endtask

   task automatic test_stall();
      do_reset();
      phase_in = 4'b1000;
      cyc(3);
      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         checks++;
         if (stalled_b !== (i == 10)) begin
            errors++;
            $display("FAIL stall_cyc%0d got=%b exp=%b", i, stalled_b, (i == 10));
         end
      end
      phase_in = 4'b1100;
      cyc(2);
      checks++;
      if (stalled_b !== 1'b1) begin errors++; $display("FAIL stall_hold got=0 exp=1"); end
      cyc(1);
      checks++;
      if ({step_fwd_b, stalled_b} !== 2'b10) begin
         errors++;
         $display("FAIL stall_drop got=%b%b exp=10", step_fwd_b, stalled_b);
      end
      cyc(2);
      reset = 1'b1;
      cyc(1);
      checks++;
      if ({phase_idx_b, step_fwd_b, step_rev_b, dir_b, position_b, locked_b, err_skip_b,
           err_illegal_b, stalled_b} !== 14'd0) begin
         errors++;
         $display("FAIL mid_reset got=%h exp=0", {phase_idx_b, step_fwd_b, step_rev_b, dir_b,
                  position_b, locked_b, err_skip_b, err_illegal_b, stalled_b});
      end
      reset = 1'b0;
   endtask

   initial begin
      ptab = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
      test_reset();
      test_forward();
      test_reverse();
      test_skip();
      test_illegal();
      test_wrap();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
